// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 16-bit pipelined CPU.
// Holds the PC, applies control-unit redirects/flushes, and freezes on the halt opcode.
module fetch_stage #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic [1:0]      pc_src,
    input  logic            flush,
    input  logic [PC_W-1:0] branch_target,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [15:0]     if_id_instr,
    output logic [PC_W-1:0] if_id_pc_plus2,
    output logic            if_id_valid,
    output logic            halted,
    output logic [15:0]     fetch_count
);

    typedef enum logic [1:0] {
        SRC_BRANCH = 2'b00,
        SRC_SEQ    = 2'b01,
        SRC_JUMP   = 2'b10,
        SRC_HOLD   = 2'b11
    } pc_src_e;

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(1);

    pc_src_e         src;
    logic [PC_W-1:0] pc_q, pc_d, pc_plus2;
    logic [15:0]     if_id_instr_q, if_id_instr_d;
    logic [PC_W-1:0] if_id_pc_plus2_q, if_id_pc_plus2_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic            halted_q, halted_d;
    logic [15:0]     fetch_count_q, fetch_count_d;

    always_comb begin
        src              = pc_src_e'(pc_src);
        pc_plus2         = pc_q + PC_W'(2);
        pc_d             = pc_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus2_d = if_id_pc_plus2_q;
        if_id_valid_d    = if_id_valid_q;
        fetch_count_d    = fetch_count_q;
        // Only a real instruction can halt; bubbles carry opcode 0 but are ignored.
        halted_d         = halted_q | (if_id_valid_q & (if_id_instr_q[15:12] == 4'd0));

        if (!halted_q && !stall) begin
            unique case (src)
                SRC_JUMP:   pc_d = jump_target & ALIGN_MASK;
                SRC_BRANCH: pc_d = branch_target & ALIGN_MASK;
                SRC_SEQ:    pc_d = pc_plus2;
                SRC_HOLD:   pc_d = pc_q;
                default:    pc_d = pc_q;
            endcase

            if (flush || src == SRC_JUMP) begin
                if_id_instr_d    = '0;
                if_id_pc_plus2_d = '0;
                if_id_valid_d    = 1'b0;
            end else begin
                if_id_instr_d    = imem_data;
                if_id_pc_plus2_d = pc_plus2;
                if_id_valid_d    = 1'b1;
                if (fetch_count_q != '1) begin
                    fetch_count_d = fetch_count_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q             <= RESET_PC;
            if_id_instr_q    <= '0;
            if_id_pc_plus2_q <= '0;
            if_id_valid_q    <= 1'b0;
            halted_q         <= 1'b0;
            fetch_count_q    <= '0;
        end else begin
            pc_q             <= pc_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_plus2_q <= if_id_pc_plus2_d;
            if_id_valid_q    <= if_id_valid_d;
            halted_q         <= halted_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc_plus2 = if_id_pc_plus2_q;
    assign if_id_valid    = if_id_valid_q;
    assign halted         = halted_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus randomized
// stimulus, all checked every cycle against a behavioural front-end model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pc_src = 2'b01;
    logic        flush = 1'b0;
    logic [15:0] branch_target = '0;
    logic [15:0] jump_target = '0;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:32767];

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model of the front end.
    int          m_pc, m_pp2, m_count;
    logic [15:0] m_instr;
    logic        m_valid, m_halted, m_new_halt;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[15:1]];

    fetch_stage #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .pc_src         (pc_src),
        .flush          (flush),
        .branch_target  (branch_target),
        .jump_target    (jump_target),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_pp2 = 0; m_count = 0;
            m_instr = '0; m_valid = 1'b0; m_halted = 1'b0;
        end else begin
            m_new_halt = m_halted || (m_valid && m_instr[15:12] == 4'h0);
            if (!m_halted && !stall) begin
                if (flush || pc_src == 2'b10) begin
                    m_instr = '0; m_pp2 = 0; m_valid = 1'b0;
                end else begin
                    m_instr = mem[m_pc / 2];
                    m_pp2   = (m_pc + 2) % 65536;
                    m_valid = 1'b1;
                    if (m_count < 65535) m_count = m_count + 1;
                end
                case (pc_src)
                    2'b10:   m_pc = int'(jump_target) / 2 * 2;
                    2'b00:   m_pc = int'(branch_target) / 2 * 2;
                    2'b01:   m_pc = (m_pc + 2) % 65536;
                    default: m_pc = m_pc;
                endcase
            end
            m_halted = m_new_halt;
        end
    end

    always @(negedge clk) begin
        chk("imem_addr", int'(imem_addr), m_pc);
        chk("if_id_instr", int'(if_id_instr), int'(m_instr));
        chk("if_id_pc_plus2", int'(if_id_pc_plus2), m_pp2);
        chk("if_id_valid", int'(if_id_valid), int'(m_valid));
        chk("halted", int'(halted), int'(m_halted));
        chk("fetch_count", int'(fetch_count), m_count);
    end

    task automatic drive(input logic s, input logic [1:0] src, input logic f,
                         input logic [15:0] bt, input logic [15:0] jt);
        stall = s; pc_src = src; flush = f; branch_target = bt; jump_target = jt;
    endtask

    // Advance one edge; leaves time at posedge+2.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_mem(input int zero_one_in);
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'($urandom);
            if (mem[i][15:12] == 4'h0) mem[i][15:12] = 4'h1;
            if (($urandom % zero_one_in) == 0) mem[i][15:12] = 4'h0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        fill_mem(1000000);
        mem[0] = 16'hF123; mem[1] = 16'hF456; mem[2] = 16'hA210; mem[3] = 16'hB333;
        mem[16'h20] = 16'hC444; mem[16'h10] = 16'hE666; mem[16'h7FFF] = 16'h7777;
        #12;
        chk("reset_addr", int'(imem_addr), 0);
        chk("reset_valid", int'(if_id_valid), 0);
        chk("reset_count", int'(fetch_count), 0);
        rst_n = 1'b1;

        // Sequential fetch
        drive(0, 2'b01, 0, 16'h0, 16'h0);
        step();
        chk("seq_instr0", int'(if_id_instr), 16'hF123);
        chk("seq_pp2_0", int'(if_id_pc_plus2), 2);
        chk("seq_valid0", int'(if_id_valid), 1);
        chk("seq_addr1", int'(imem_addr), 2);
        step();
        chk("seq_instr1", int'(if_id_instr), 16'hF456);
        step();
        chk("seq_instr2", int'(if_id_instr), 16'hA210);
        chk("seq_count", int'(fetch_count), 3);
        chk("seq_addr3", int'(imem_addr), 6);

        // Jump with one bubble
        drive(0, 2'b10, 1, 16'h0, 16'h0041);
        step();
        chk("jmp_addr", int'(imem_addr), 16'h0040);
        chk("jmp_bubble", int'(if_id_valid), 0);
        chk("jmp_count", int'(fetch_count), 3);
        drive(0, 2'b01, 0, 16'h0, 16'h0);
        step();
        chk("jmp_instr", int'(if_id_instr), 16'hC444);
        chk("jmp_pp2", int'(if_id_pc_plus2), 16'h0042);
        chk("bubble_no_halt", int'(halted), 0);

        // Stall over a redirect
        drive(1, 2'b00, 1, 16'h0020, 16'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_addr", int'(imem_addr), 16'h0042);
            chk("stall_instr", int'(if_id_instr), 16'hC444);
            chk("stall_count", int'(fetch_count), 4);
        end
        drive(0, 2'b00, 1, 16'h0020, 16'h0);
        step();
        chk("br_addr", int'(imem_addr), 16'h0020);
        chk("br_bubble", int'(if_id_valid), 0);
        drive(0, 2'b01, 0, 16'h0, 16'h0);
        step();
        chk("br_instr", int'(if_id_instr), 16'hE666);
        chk("br_count", int'(fetch_count), 5);

        // Wrap-around
        drive(0, 2'b10, 1, 16'h0, 16'hFFFF);
        step();
        chk("wrap_addr0", int'(imem_addr), 16'hFFFE);
        drive(0, 2'b01, 0, 16'h0, 16'h0);
        step();
        chk("wrap_addr1", int'(imem_addr), 0);
        chk("wrap_instr", int'(if_id_instr), 16'h7777);
        chk("wrap_pp2", int'(if_id_pc_plus2), 0);
        chk("wrap_count", int'(fetch_count), 6);

        // Async reset in the middle of a redirect
        drive(0, 2'b10, 1, 16'h0, 16'h0100);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_addr", int'(imem_addr), 0);
        chk("arst_instr", int'(if_id_instr), 0);
        chk("arst_valid", int'(if_id_valid), 0);
        chk("arst_count", int'(fetch_count), 0);
        step();
        rst_n = 1'b1;
        drive(0, 2'b01, 0, 16'h0, 16'h0);
        step();
        chk("arst_restart_addr", int'(imem_addr), 2);
        chk("arst_restart_instr", int'(if_id_instr), 16'hF123);
        chk("arst_restart_count", int'(fetch_count), 1);

        // Halt at PC=8
        mem[4] = 16'h0000; mem[5] = 16'h9999;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk("halt_in_ifid", int'(if_id_instr), 0);
        chk("halt_not_yet", int'(halted), 0);
        step();
        chk("halt_set", int'(halted), 1);
        chk("halt_addr", int'(imem_addr), 12);
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom), 2'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            step();
            chk("halt_frozen", int'(imem_addr), 12);
        end

        // Randomized episodes
        for (int ep = 0; ep < 3; ep++) begin
            rst_n = 1'b0;
            fill_mem(512);
            do_reset();
            for (int c = 0; c < 2000; c++) begin
                drive(($urandom % 5) == 0, (($urandom % 3) == 0) ? 2'($urandom) : 2'b01,
                      ($urandom % 4) == 0, 16'($urandom), 16'($urandom));
                if (($urandom % 300) == 0) begin
                    rst_n = 1'b0;
                    #1 rst_n = 1'b1;
                end
                step();
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined CPU. Sits directly upstream of the decode stage and its control unit. It:
- holds the PC and presents the fetch address to instruction memory;
- latches the fetched instruction into IF/ID;
- consumes the control unit's PC-select and flush outputs, applying redirects and squashing wrong-path instructions;
- detects the halt opcode and freezes the front end.

## Interface
Parameters:
- PC_W, 16, PC and target width (byte address, 16-bit instructions).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- stall  in  1  hazard hold from decode: freeze PC and IF/ID.
- pc_src  in  2  next-PC select from the control unit:
  - 00 = branch_target
  - 01 = PC+2
  - 10 = jump_target
  - 11 = hold
- flush  in  1  squash the instruction being fetched this cycle.
- branch_target  in  PC_W  branch destination computed in decode.
- jump_target  in  PC_W  jump destination computed in decode.
- imem_addr  out  PC_W  fetch address; combinationally equal to PC.
- imem_data  in  16  instruction at imem_addr (combinational read).
- if_id_instr  out  16  IF/ID instruction; opcode is bits [15:12].
- if_id_pc_plus2  out  PC_W  PC+2 of the IF/ID instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
  - 0 = bubble; decode must gate all control with this bit.
- halted  out  1  sticky: a valid opcode-0 instruction reached IF/ID.
- fetch_count  out  16  number of valid instructions loaded into IF/ID; saturating.

## Operation
- **Reset values.** PC=RESET_PC, if_id_instr=0, if_id_pc_plus2=0, if_id_valid=0, halted=0, fetch_count=0. Reset is asynchronous and may assert mid-operation, aborting any redirect in flight.
- **Next-PC priority** (highest first):
  1. halted → hold.
  2. stall → hold.
  3. pc_src=10 → jump_target.
  4. pc_src=00 → branch_target.
  5. pc_src=01 → PC+2.
  6. pc_src=11 → hold.
- **Target alignment.** Bit 0 of any target is forced to 0.
- **Wrap-around.** PC+2 wraps modulo 2^PC_W (0xFFFE → 0x0000 for PC_W=16).
- **IF/ID update** (same priority order):
  - halted → hold all IF/ID fields.
  - stall → hold all IF/ID fields; a simultaneous flush or redirect is ignored, because decode re-presents the same instruction next cycle.
  - flush=1 or pc_src=10 → load a bubble: instr=0, valid=0, pc_plus2=0.
  - otherwise → load instr=imem_data, pc_plus2=PC+2, valid=1.
- **Halt.** halted sets on the edge after if_id_valid=1 with if_id_instr[15:12]=0. It stays set until reset. Bubbles (valid=0) never trigger halt, even though their opcode field is 0.
- **fetch_count.** Increments by 1 on each edge that loads valid=1 into IF/ID. It holds at 16'hFFFF and does not wrap.
- **pc_src=11 without stall.** PC holds but IF/ID still reloads. The same instruction is therefore fetched again; this is legal and counted.

## Timing
- **Fetch latency.** The instruction at PC appears in IF/ID one edge later.
- **Redirect.** Decode presents the redirect (pc_src 00/10 plus flush) in cycle n.
  - PC = target after edge n.
  - IF/ID holds a bubble during cycle n+1.
  - The target instruction is valid in IF/ID after edge n+1.
  - Penalty: exactly one bubble.
- **Stall.** Each stalled cycle adds one cycle. Release resumes from the held state, with no lost or duplicated instruction.
- **Halt.** The halt instruction is in IF/ID during cycle n, halted=1 after edge n. imem_addr is frozen from that edge on.
- **Combinational path.** imem_addr is combinational from the PC register only; no input-to-output combinational path exists.

## Test plan
- **Sequential fetch.** Reset release; pc_src=01; imem returns 0xF123, 0xF456, 0xA210 → imem_addr 0, 2, 4. IF/ID shows 0xF123 with pc_plus2=2 and valid=1, then 0xF456, then 0xA210. fetch_count reaches 3.
- **Jump.** At PC=6, pc_src=10, jump_target=0x0041 → next imem_addr=0x0040. One cycle with if_id_valid=0, then the 0x0040 instruction with valid=1. fetch_count does not count the bubble.
- **Stall over redirect.** stall=1 for 2 cycles while pc_src=00, branch_target=0x0020, flush=1 → PC and IF/ID unchanged both cycles. After release, the redirect applies with a single bubble.
- **Halt.** imem returns 0x0000 at PC=8 → halted=1 one edge after it enters IF/ID; imem_addr stays fixed for 10 further cycles. Separately, a flush-generated bubble (valid=0, instr=0) leaves halted=0.
- **Wrap.** Redirect to 0xFFFE, then pc_src=01 → imem_addr sequence 0xFFFE, 0x0000.
- **Async reset mid-redirect.** Present a jump, then drop rst_n mid-cycle → outputs return to reset values immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC with halted=0 and fetch_count=0.
